// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the clock ratio monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } mon_state_t;

  // Saturation value of a width-bit period counter.
  function automatic int unsigned cnt_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  // Absolute difference (already computed) against the allowed tolerance.
  function automatic logic within_tol(input int unsigned diff_abs, input int unsigned tol);
    return (diff_abs <= tol);
  endfunction

endpackage

// File: rtl/clk_mon_edge_det.sv
// Rising-edge detector for the divided gate stream; rise is same-cycle.
module clk_mon_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic gate_i,
  output logic rise
);

  logic gate_q;

  // One-cycle history of the gate stream.
  always_ff @(posedge clk) begin
    if (reset) gate_q <= 1'b0;
    else       gate_q <= gate_i;
  end

  assign rise = gate_i & ~gate_q;

endmodule

// File: rtl/clk_ratio_monitor.sv
// Clock ratio monitor: measures cycles between rising edges of gate_i and
// compares each period with exp_period_i, reporting period, lock and errors.
//
// State table:
//   ST_IDLE    | monitor disabled, waiting for en
//   ST_ARM     | waiting for the first rising edge to start a period
//   ST_MEASURE | each rising edge closes a period and is checked
//
// Optional build macro CLK_MON_MINMAX_EN adds period_min_o / period_max_o.
module clk_ratio_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned p_cnt_bits   = 8,
  parameter int unsigned p_lock_count = 4,
  parameter int unsigned p_tol        = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  gate_i,
  input  logic [p_cnt_bits-1:0] exp_period_i,
  output logic [p_cnt_bits-1:0] period_o,
  output logic                  valid_o,
  output logic                  lock_o,
  output logic                  err_o,
  output logic                  timeout_o
`ifdef CLK_MON_MINMAX_EN
  ,
  output logic [p_cnt_bits-1:0] period_min_o,
  output logic [p_cnt_bits-1:0] period_max_o
`endif
);

  localparam logic [p_cnt_bits-1:0] CNT_MAX_V = p_cnt_bits'(cnt_max(p_cnt_bits));
  localparam logic [p_cnt_bits-1:0] CNT_ONE   = p_cnt_bits'(1);
  localparam logic [3:0]            LOCK_N    = 4'(p_lock_count);

  mon_state_t            state_q, state_d;
  logic [p_cnt_bits-1:0] cnt_q, cnt_d;
  logic [3:0]            match_q, match_d;
  logic [p_cnt_bits-1:0] period_d;
  logic                  valid_d, lock_d, err_d, timeout_d;
  logic                  rise;
  logic [p_cnt_bits:0]   diff_abs;
  logic                  in_tol;

  clk_mon_edge_det u_edge_det (
    .clk    (clk),
    .reset  (reset),
    .gate_i (gate_i),
    .rise   (rise)
  );

  // Difference kept one bit wider than the counter so it never wraps.
  always_comb begin
    diff_abs = '0;
    if (cnt_q >= exp_period_i) diff_abs = {1'b0, cnt_q} - {1'b0, exp_period_i};
    else                       diff_abs = {1'b0, exp_period_i} - {1'b0, cnt_q};
    in_tol = within_tol(32'(diff_abs), p_tol);
  end

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    period_d  = period_o;
    lock_d    = lock_o;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      match_d = '0;
      lock_d  = 1'b0;
    end else begin
      if (rise)                    cnt_d = CNT_ONE;
      else if (cnt_q != CNT_MAX_V) cnt_d = cnt_q + CNT_ONE;
      case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM:  if (rise) state_d = ST_MEASURE;
        ST_MEASURE: begin
          if (rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            if (in_tol) begin
              if (match_q < LOCK_N) match_d = match_q + 4'd1;
              if (match_d >= LOCK_N) lock_d = 1'b1;
            end else begin
              err_d   = 1'b1;
              match_d = '0;
              lock_d  = 1'b0;
            end
          end else if (cnt_q == CNT_MAX_V) begin
            // A rise on the saturating cycle is a valid max-length period.
            timeout_d = 1'b1;
            match_d   = '0;
            lock_d    = 1'b0;
            state_d   = ST_ARM;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      match_q   <= '0;
      period_o  <= '0;
      valid_o   <= 1'b0;
      lock_o    <= 1'b0;
      err_o     <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      period_o  <= period_d;
      valid_o   <= valid_d;
      lock_o    <= lock_d;
      err_o     <= err_d;
      timeout_o <= timeout_d;
    end
  end

`ifdef CLK_MON_MINMAX_EN
  // Running extremes of measured periods, restarted whenever the monitor is disabled.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      period_min_o <= CNT_MAX_V;
      period_max_o <= '0;
    end else if (valid_d) begin
      if (period_d < period_min_o) period_min_o <= period_d;
      if (period_d > period_max_o) period_max_o <= period_d;
    end
  end
`endif

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Self-checking bench for clk_ratio_monitor with a cycle-level reference model
// based on "cycles elapsed since the last rising edge".
module tb_clk_ratio_monitor;

  localparam int W    = 4;
  localparam int LOCK = 4;
  localparam int TOL  = 1;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset, en, gate;
  logic [W-1:0] exp_p;
  logic [W-1:0] period_o;
  logic         valid_o, lock_o, err_o, timeout_o;
`ifdef CLK_MON_MINMAX_EN
  logic [W-1:0] period_min_o, period_max_o;
`endif

  clk_ratio_monitor #(
    .p_cnt_bits   (W),
    .p_lock_count (LOCK),
    .p_tol        (TOL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .gate_i       (gate),
    .exp_period_i (exp_p),
    .period_o     (period_o),
    .valid_o      (valid_o),
    .lock_o       (lock_o),
    .err_o        (err_o),
    .timeout_o    (timeout_o)
`ifdef CLK_MON_MINMAX_EN
    ,
    .period_min_o (period_min_o),
    .period_max_o (period_max_o)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: gate history, elapsed cycles since last rise, and
  // whether a start edge has been seen since enabling / timeout.
  int  m_prev_gate = 0;
  int  m_elapsed   = 0;
  bit  m_enabled   = 0;
  bit  m_started   = 0;
  int  m_streak    = 0;
  int  m_lock      = 0;
  int  m_period    = 0;
  int  m_valid     = 0;
  int  m_err       = 0;
  int  m_tout      = 0;
  int  m_min       = MAXC;
  int  m_max       = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_update();
    int  rise;
    int  diff;
    rise = (gate && m_prev_gate == 0) ? 1 : 0;
    m_valid = 0; m_err = 0; m_tout = 0;
    if (reset) begin
      m_prev_gate = 0; m_elapsed = 0; m_enabled = 0; m_started = 0;
      m_streak = 0; m_lock = 0; m_period = 0; m_min = MAXC; m_max = 0;
      return;
    end
    m_prev_gate = gate ? 1 : 0;
    if (!en) begin
      m_enabled = 0; m_started = 0; m_elapsed = 0;
      m_streak = 0; m_lock = 0; m_min = MAXC; m_max = 0;
      return;
    end
    if (!m_enabled) begin
      m_enabled = 1;
    end else if (!m_started) begin
      if (rise == 1) m_started = 1;
    end else if (rise == 1) begin
      m_period = m_elapsed;
      m_valid  = 1;
      diff = m_elapsed - int'(exp_p);
      if (diff < 0) diff = -diff;
      if (diff <= TOL) begin
        if (m_streak < LOCK) m_streak++;
        if (m_streak >= LOCK) m_lock = 1;
      end else begin
        m_err = 1; m_streak = 0; m_lock = 0;
      end
      if (m_period < m_min) m_min = m_period;
      if (m_period > m_max) m_max = m_period;
    end else if (m_elapsed == MAXC) begin
      m_tout = 1; m_streak = 0; m_lock = 0; m_started = 0;
    end
    if (rise == 1)             m_elapsed = 1;
    else if (m_elapsed < MAXC) m_elapsed++;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    chk("period_o",  32'(period_o),  m_period);
    chk("valid_o",   32'(valid_o),   m_valid);
    chk("lock_o",    32'(lock_o),    m_lock);
    chk("err_o",     32'(err_o),     m_err);
    chk("timeout_o", 32'(timeout_o), m_tout);
`ifdef CLK_MON_MINMAX_EN
    chk("period_min_o", 32'(period_min_o), m_min);
    chk("period_max_o", 32'(period_max_o), m_max);
`endif
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulses(input int per, input int k);
    for (int i = 0; i < k; i++) begin
      gate = 1'b1;
      step();
      gate = 1'b0;
      cycles(per - 1);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; gate = 1'b0; exp_p = W'(4);
    // Reset and idle-low gate.
    cycles(5);
    chk("reset_period", 32'(period_o), 0);
    chk("reset_lock",   32'(lock_o),   0);
    reset = 1'b0; en = 1'b1;
    cycles(6);

    // Steady period 4 -> lock on 4th measurement.
    pulses(4, 6);
    chk("lock_at_4", 32'(lock_o), 1);

    // Switch to period 8: error, then relock at exp=8.
    pulses(8, 2);
    exp_p = W'(8);
    pulses(8, 5);
    chk("relock_at_8", 32'(lock_o), 1);

    // Tolerance window around 6.
    exp_p = W'(6);
    pulses(5, 1); pulses(7, 1); pulses(6, 1); pulses(5, 1); pulses(8, 1);
    pulses(6, 1);

    // Full-scale period: rise on saturation counts as a measurement.
    exp_p = W'(15);
    pulses(15, 6);

    // Stuck-high gate after lock -> timeout, then re-arm.
    gate = 1'b1;
    cycles(20);
    gate = 1'b0;
    step();
    pulses(3, 3);
    cycles(20);

    // Disable and reset mid-period.
    exp_p = W'(4);
    pulses(4, 6);
    gate = 1'b1; step(); gate = 1'b0; cycles(2);
    en = 1'b0; cycles(3); en = 1'b1;
    pulses(4, 6);
    gate = 1'b1; step(); gate = 1'b0; cycles(1);
    reset = 1'b1; step(); reset = 1'b0;
    cycles(3);

    // Min/max tracking.
    en = 1'b0; step(); en = 1'b1; step();
    pulses(4, 1); pulses(4, 1); pulses(6, 1); pulses(5, 1);
    gate = 1'b1; step(); gate = 1'b0; cycles(2);

    // Randomised period trains, expectations, enable drops and resets.
    for (int it = 0; it < 60; it++) begin
      int r;
      r = int'($urandom_range(0, 15));
      if (r == 0) begin
        reset = 1'b1; step(); reset = 1'b0;
      end else if (r < 3) begin
        en = 1'b0; cycles(int'($urandom_range(1, 3))); en = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) exp_p = W'($urandom_range(2, MAXC));
      pulses(int'($urandom_range(2, MAXC)), int'($urandom_range(1, 4)));
    end
    cycles(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
